// File: rtl/clock_period_meter.sv
// clock_period_meter: measures the rising-edge period of a slow divided clock
// in system-clock cycles, classifies it as fast/slow/out-of-range and flags a
// stalled input.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// S_IDLE    | after reset, waiting for the first (reference) rising edge
// S_MEASURE | reference edge seen; each further edge reports a period
// S_STALLED | no edge for TIMEOUT clocks; next edge is only a new reference
module clock_period_meter #(
  parameter int CNT_WIDTH   = 20,
  parameter int FAST_PERIOD = 250000,
  parameter int SLOW_PERIOD = 500000,
  parameter int TOL         = 2500,
  parameter int TIMEOUT     = 1000000
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 slow_clock,
  output logic [CNT_WIDTH-1:0] period_out,
  output logic                 period_valid,
  output logic                 speed_fast,
  output logic                 speed_slow,
  output logic                 out_of_range,
  output logic                 stalled
);

  // Window limits carry one extra bit so the +/- TOL arithmetic cannot wrap.
  localparam logic [CNT_WIDTH:0]   FAST_LO = (CNT_WIDTH+1)'(FAST_PERIOD - TOL);
  localparam logic [CNT_WIDTH:0]   FAST_HI = (CNT_WIDTH+1)'(FAST_PERIOD + TOL);
  localparam logic [CNT_WIDTH:0]   SLOW_LO = (CNT_WIDTH+1)'(SLOW_PERIOD - TOL);
  localparam logic [CNT_WIDTH:0]   SLOW_HI = (CNT_WIDTH+1)'(SLOW_PERIOD + TOL);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(TIMEOUT);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_MEASURE = 2'd1,
    S_STALLED = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_sync1;
  logic                  r_sync2;
  logic                  r_sync3;
  logic                  r_edge;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic                  w_edge;
  logic                  w_timeout;
  logic                  w_capture;
  logic                  w_stall;
  logic                  w_resume;
  logic [CNT_WIDTH:0]    w_cnt_ext;
  logic                  w_in_fast;
  logic                  w_in_slow;

  assign w_edge    = r_sync2 & ~r_sync3;
  assign w_timeout = (r_cnt == CNT_MAX);
  assign w_cnt_ext = {1'b0, r_cnt};
  assign w_in_fast = (w_cnt_ext >= FAST_LO) && (w_cnt_ext <= FAST_HI);
  assign w_in_slow = (w_cnt_ext >= SLOW_LO) && (w_cnt_ext <= SLOW_HI);

  // Synchronise slow_clock and register the rising-edge strobe; the extra
  // strobe flop fixes the edge-to-valid latency at three clocks.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
      r_edge  <= 1'b0;
    end else begin
      r_sync1 <= slow_clock;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
      r_edge  <= w_edge;
    end
  end

  // Period counter: restarts at 1 on an edge, saturates at TIMEOUT.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_cnt <= '0;
    end else if (r_edge) begin
      r_cnt <= CNT_ONE;
    end else if (!w_timeout) begin
      r_cnt <= r_cnt + CNT_ONE;
    end
  end

  // State register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; an edge always takes priority over a timeout.
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_stall     = 1'b0;
    w_resume    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_edge) begin
          w_state_nxt = S_MEASURE;
        end else if (w_timeout) begin
          w_state_nxt = S_STALLED;
          w_stall     = 1'b1;
        end
      end
      S_MEASURE: begin
        if (r_edge) begin
          w_capture = 1'b1;
        end else if (w_timeout) begin
          w_state_nxt = S_STALLED;
          w_stall     = 1'b1;
        end
      end
      S_STALLED: begin
        if (r_edge) begin
          w_state_nxt = S_MEASURE;
          w_resume    = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Output registers: capture and classify on a measured edge, clear the
  // classification on a stall, period_out holds across a stall.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      period_out   <= '0;
      period_valid <= 1'b0;
      speed_fast   <= 1'b0;
      speed_slow   <= 1'b0;
      out_of_range <= 1'b0;
      stalled      <= 1'b0;
    end else begin
      period_valid <= w_capture;
      if (w_capture) begin
        period_out   <= r_cnt;
        speed_fast   <= w_in_fast;
        speed_slow   <= w_in_slow & ~w_in_fast;
        out_of_range <= ~w_in_fast & ~w_in_slow;
      end else if (w_stall) begin
        stalled      <= 1'b1;
        speed_fast   <= 1'b0;
        speed_slow   <= 1'b0;
        out_of_range <= 1'b0;
      end else if (w_resume) begin
        stalled      <= 1'b0;
      end
    end
  end

endmodule
